ex_muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the Execute stage, beside the ALU.
- Fed from the ID/EX register outputs, with forwarded operands.
- Holds F/D/E via a stall output while it computes.
- Returns a single-cycle result, which the EX/MEM register captures on the cycle the stall drops.

---
 rtl/muldiv_pkg.sv | 13 +
 rtl/muldiv_signfix.sv | 16 +
 rtl/ex_muldiv_unit.sv | 117 +++++++++++
 tb/tb_ex_muldiv_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and iteration bound for the M-extension unit
package muldiv_pkg;
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;
  localparam logic [4:0] ITER_LAST = 5'd31;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: two independent conditional two's-complement negators
// ports: a/b values in, neg_a/neg_b select negation, ya/yb results out
module muldiv_signfix #(
  parameter int WA = 32,
  parameter int WB = 32
) (
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
  input  logic          neg_a,
  input  logic          neg_b,
  output logic [WA-1:0] ya,
  output logic [WB-1:0] yb
);
  assign ya = neg_a ? -a : a;
  assign yb = neg_b ? -b : b;
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the Execute stage
// ports: clk, reset (async active-low), MulDivE start, funct3E op, SrcAE/SrcBE operands,
//        FlushE abort; StallMD hazard stall, DoneE one-cycle result strobe, MulDivResultE result
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MulDivE,
  input  logic [2:0]       funct3E,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             FlushE,
  output logic             StallMD,
  output logic             DoneE,
  output logic [WIDTH-1:0] MulDivResultE
);
  state_t             state;
  logic [4:0]         cnt;
  logic [2:0]         op;
  logic [WIDTH-1:0]   m;
  logic               a_neg, res_neg;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic               is_div_in, a_sgn_in, b_sgn_in, an_in, bn_in, div0, ovf;
  logic [WIDTH-1:0]   a_mag, b_mag, spec_res, final_res;
  logic [WIDTH:0]     mul_sum, rem_sh, rem_df;
  logic               div_ok;
  logic [WIDTH-1:0]   rem_nx, fb;
  logic [2*WIDTH-1:0] mul_nx, div_nx, prod_nx, fa;
  assign is_div_in = funct3E[2];
  assign a_sgn_in  = (funct3E == OP_MULH) | (funct3E == OP_MULHSU) | (funct3E == OP_DIV) | (funct3E == OP_REM);
  assign b_sgn_in  = (funct3E == OP_MULH) | (funct3E == OP_DIV) | (funct3E == OP_REM);
  assign an_in     = a_sgn_in & SrcAE[WIDTH-1];
  assign bn_in     = b_sgn_in & SrcBE[WIDTH-1];
  assign div0      = is_div_in & (SrcBE == '0);
  assign ovf       = ((funct3E == OP_DIV) | (funct3E == OP_REM)) &
                     (SrcAE == {1'b1, {(WIDTH-1){1'b0}}}) & (SrcBE == '1);
  // funct3[1] picks remainder among the divide ops
  assign spec_res  = funct3E[1] ? (div0 ? SrcAE : '0) : (div0 ? '1 : {1'b1, {(WIDTH-1){1'b0}}});
  muldiv_signfix #(.WA(WIDTH), .WB(WIDTH)) u_prep (
    .a(SrcAE), .b(SrcBE), .neg_a(an_in), .neg_b(bn_in), .ya(a_mag), .yb(b_mag)
  );
  // multiply: prod = {partial high, remaining multiplier bits}, add m when the low bit is set
  assign mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, prod[0] ? m : '0};
  assign mul_nx  = {mul_sum, prod[WIDTH-1:1]};
  // divide: prod[WIDTH-1:0] shifts dividend bits out and quotient bits in
  assign rem_sh  = {rem, prod[WIDTH-1]};
  assign rem_df  = rem_sh - {1'b0, m};
  assign div_ok  = !rem_df[WIDTH];
  assign rem_nx  = div_ok ? rem_df[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign div_nx  = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-2:0], div_ok};
  assign prod_nx = op[2] ? div_nx : mul_nx;
  // fix-up works on the final step's output so the result registers on the last CALC edge
  muldiv_signfix #(.WA(2*WIDTH), .WB(WIDTH)) u_fix (
    .a(prod_nx), .b(rem_nx), .neg_a(res_neg), .neg_b(a_neg), .ya(fa), .yb(fb)
  );
  assign final_res = op[2] ? (op[1] ? fb : fa[WIDTH-1:0])
                           : (op == OP_MUL ? fa[WIDTH-1:0] : fa[2*WIDTH-1:WIDTH]);
  assign StallMD   = reset & (((state == IDLE) & MulDivE & !FlushE) | (state == CALC));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      op            <= '0;
      m             <= '0;
      a_neg         <= 1'b0;
      res_neg       <= 1'b0;
      prod          <= '0;
      rem           <= '0;
      DoneE         <= 1'b0;
      MulDivResultE <= '0;
    end else if (FlushE) begin
      state <= IDLE;
      DoneE <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DoneE <= 1'b0;
          if (MulDivE) begin
            op      <= funct3E;
            cnt     <= '0;
            a_neg   <= an_in;
            res_neg <= an_in ^ bn_in;
            m       <= is_div_in ? b_mag : a_mag;
            prod    <= {{WIDTH{1'b0}}, is_div_in ? a_mag : b_mag};
            rem     <= '0;
            if (div0 | ovf) begin
              state         <= DONE;
              DoneE         <= 1'b1;
              MulDivResultE <= spec_res;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          prod <= prod_nx;
          rem  <= rem_nx;
          cnt  <= cnt + 5'd1;
          if (cnt == ITER_LAST) begin
            state         <= DONE;
            DoneE         <= 1'b1;
            MulDivResultE <= final_res;
          end
        end
        DONE: begin
          state <= IDLE;
          DoneE <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed self-checking bench for ex_muldiv_unit
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MulDivE = 1'b0;
  logic [2:0]  funct3E = '0;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic        FlushE = 1'b0;
  logic        StallMD, DoneE;
  logic [31:0] MulDivResultE;
  int          compared = 0;
  int          mismatched = 0;
  int          dones;
  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .MulDivE(MulDivE), .funct3E(funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .FlushE(FlushE),
    .StallMD(StallMD), .DoneE(DoneE), .MulDivResultE(MulDivResultE)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3E = f;
    SrcAE   = a;
    SrcBE   = b;
    MulDivE = 1'b1;
  endtask
  // waits from the issue cycle (n=0) until DoneE, counting stall cycles on the way
  task automatic wait_done(input string tag, input logic [31:0] exp, input int lat, input int stl);
    int n = 0;
    int s = 0;
    #1;
    while (!DoneE && n < 60) begin
      s += int'(StallMD);
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " stall cycles"}, 32'(s), 32'(stl));
    chk({tag, " result"}, MulDivResultE, exp);
    chk({tag, " stall at done"}, {31'b0, StallMD}, 32'd0);
    MulDivE = 1'b0;
    @(negedge clk);
    chk({tag, " done one cycle"}, {31'b0, DoneE}, 32'd0);
  endtask
  initial begin
    MulDivE = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset done", {31'b0, DoneE}, 32'd0);
    chk("reset result", MulDivResultE, 32'd0);
    chk("reset stall", {31'b0, StallMD}, 32'd0);
    MulDivE = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    start(OP_MUL, 32'd7, 32'hFFFFFFFD);           wait_done("mul", 32'hFFFFFFEB, 33, 33);
    start(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);  wait_done("mulhu", 32'hFFFFFFFE, 33, 33);
    start(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF);   wait_done("mulh", 32'h00000000, 33, 33);
    start(OP_MULHSU, 32'hFFFFFFFF, 32'h00000002); wait_done("mulhsu", 32'hFFFFFFFF, 33, 33);
    start(OP_DIV, 32'hFFFFFFF9, 32'd2);           wait_done("div", 32'hFFFFFFFD, 33, 33);
    start(OP_REM, 32'hFFFFFFF9, 32'd2);           wait_done("rem", 32'hFFFFFFFF, 33, 33);
    start(OP_REMU, 32'd100, 32'd7);               wait_done("remu", 32'd2, 33, 33);
    start(OP_DIVU, 32'd100, 32'd7);               wait_done("divu", 32'd14, 33, 33);
    start(OP_DIVU, 32'h1234, 32'd0);              wait_done("divu by 0", 32'hFFFFFFFF, 1, 1);
    start(OP_REM, 32'h1234, 32'd0);               wait_done("rem by 0", 32'h00001234, 1, 1);
    start(OP_DIV, 32'h80000000, 32'hFFFFFFFF);    wait_done("div ovf", 32'h80000000, 1, 1);
    start(OP_REM, 32'h80000000, 32'hFFFFFFFF);    wait_done("rem ovf", 32'h00000000, 1, 1);
    start(OP_DIVU, 32'd45, 32'd6);                wait_done("divu back", 32'd7, 33, 33);
    // flush mid-divide: no strobe, result register keeps the previous value
    start(OP_DIV, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    FlushE  = 1'b1;
    MulDivE = 1'b0;
    @(negedge clk);
    #1;
    chk("flush stall drop", {31'b0, StallMD}, 32'd0);
    FlushE = 1'b0;
    dones  = 0;
    repeat (40) begin
      @(negedge clk);
      dones += int'(DoneE);
    end
    chk("flush no done", 32'(dones), 32'd0);
    chk("flush result kept", MulDivResultE, 32'd7);
    start(OP_MUL, 32'd3, 32'd4);                  wait_done("mul after flush", 32'd12, 33, 33);
    // async reset mid-multiply with the start request still high
    start(OP_MUL, 32'd5, 32'd6);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midreset done", {31'b0, DoneE}, 32'd0);
    chk("midreset result", MulDivResultE, 32'd0);
    chk("midreset stall", {31'b0, StallMD}, 32'd0);
    @(negedge clk);
    funct3E = OP_MUL;
    SrcAE   = 32'd2;
    SrcBE   = 32'd2;
    reset   = 1'b1;
    wait_done("mul after reset", 32'd4, 33, 33);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
